// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, synchronized row sampling, per-key debounce,
// ascending-order press events queued in a 4-deep fall-through FIFO.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_pins,
  output logic [3:0]  column_pins,
  output logic [15:0] keys_stable,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic        overflow
);

  typedef enum logic [1:0] {SCAN, UPDATE, EMIT} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  c_reg, c_next;
  logic [7:0]  settle_reg, settle_next;
  logic [3:0]  idx_reg, idx_next;
  logic [3:0]  column_reg, column_next;
  logic        sample;

  logic [3:0]  sync1_reg, sync2_reg;
  logic [15:0] raw_reg;
  logic [15:0] stable_vec, pending_vec;

  logic [3:0]  fifo_reg [4];
  logic [3:0]  fifo_next [4];
  logic [2:0]  count_reg, count_next;
  logic        valid_reg, overflow_reg, overflow_next;
  logic        push, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= SCAN;
      c_reg      <= 2'd0;
      settle_reg <= 8'd0;
      idx_reg    <= 4'd0;
      column_reg <= 4'b1110;
      sync1_reg  <= 4'b1111;
      sync2_reg  <= 4'b1111;
    end else begin
      state_reg  <= state_next;
      c_reg      <= c_next;
      settle_reg <= settle_next;
      idx_reg    <= idx_next;
      column_reg <= column_next;
      sync1_reg  <= row_pins;
      sync2_reg  <= sync1_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    c_next      = c_reg;
    settle_next = settle_reg;
    idx_next    = idx_reg;
    sample      = 1'b0;
    column_next = 4'b1111;
    case (state_reg)
      SCAN: begin
        if (settle_reg == 8'(SETTLE_CYCLES - 1)) begin
          sample      = 1'b1;
          settle_next = 8'd0;
          if (c_reg == 2'd3) state_next = UPDATE;
          else               c_next     = c_reg + 2'd1;
        end else begin
          settle_next = settle_reg + 8'd1;
        end
      end
      UPDATE: begin
        state_next = EMIT;
        idx_next   = 4'd0;
      end
      EMIT: begin
        if (idx_reg == 4'd15) begin
          state_next = SCAN;
          c_next     = 2'd0;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end
      default: state_next = SCAN;
    endcase
    // Drive computed from the next state so the pin register lines up with the FSM.
    if (state_next == SCAN) column_next = ~(4'b0001 << c_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_reg <= 16'd0;
    end else if (sample) begin
      for (int r = 0; r < 4; r++) raw_reg[{2'(r), c_reg}] <= ~sync2_reg[r];
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_key
      logic [3:0] cnt_reg;
      logic       stable_reg, pending_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg     <= 4'd0;
          stable_reg  <= 1'b0;
          pending_reg <= 1'b0;
        end else if (state_reg == UPDATE) begin
          if (raw_reg[gi] == stable_reg) begin
            cnt_reg <= 4'd0;
          end else if (cnt_reg == 4'(DEBOUNCE_SCANS - 1)) begin
            cnt_reg    <= 4'd0;
            stable_reg <= raw_reg[gi];
            if (raw_reg[gi]) pending_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end else if (state_reg == EMIT && idx_reg == 4'(gi)) begin
          pending_reg <= 1'b0;
        end
      end

      assign stable_vec[gi]  = stable_reg;
      assign pending_vec[gi] = pending_reg;
    end
  endgenerate

  assign push = (state_reg == EMIT) && pending_vec[idx_reg];
  assign pop  = valid_reg && key_ready;

  // Shift-register FIFO: slot 0 is always the head, so key_code is a plain flop.
  always_comb begin
    logic [2:0] level;
    for (int k = 0; k < 4; k++) fifo_next[k] = fifo_reg[k];
    overflow_next = overflow_reg;
    level         = count_reg;
    if (pop) begin
      for (int k = 0; k < 3; k++) fifo_next[k] = fifo_reg[k+1];
      fifo_next[3] = 4'd0;
      level        = count_reg - 3'd1;
    end
    count_next = level;
    if (push) begin
      if (level != 3'd4) begin
        fifo_next[level[1:0]] = idx_reg;
        count_next            = level + 3'd1;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) fifo_reg[k] <= 4'd0;
      count_reg    <= 3'd0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) fifo_reg[k] <= fifo_next[k];
      count_reg    <= count_next;
      valid_reg    <= (count_next != 3'd0);
      overflow_reg <= overflow_next;
    end
  end

  assign column_pins = column_reg;
  assign keys_stable = stable_vec;
  assign key_valid   = valid_reg;
  assign key_code    = fifo_reg[0];
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a 4x4 switch-matrix model on the pins.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_pins;
  logic [3:0]  column_pins;
  logic [15:0] keys_stable;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        overflow;

  logic [15:0] pressed;
  int          cyc = 0;
  int          valid_cnt = 0;
  int          pop_n = 0;
  int          pop_log [64];
  int          n_checks = 0;
  int          n_pass = 0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .row_pins(row_pins), .column_pins(column_pins),
    .keys_stable(keys_stable), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows idle high.
  always_comb begin
    for (int r = 0; r < 4; r++) row_pins[r] = ~|(pressed[r*4 +: 4] & ~column_pins);
  end

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (key_valid) valid_cnt <= valid_cnt + 1;
      if (key_valid && key_ready && pop_n < 64) begin
        pop_log[pop_n] <= int'(key_code);
        pop_n <= pop_n + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic goto_phase(input int p);
    while (cyc % 33 != p) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, 32'(column_pins), 32'hE);
    check({tag, "_stable"}, 32'(keys_stable), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_code"}, 32'(key_code), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_col;
    int base_v, base_p;
    rst = 1'b1;
    key_ready = 1'b0;
    pressed = 16'h0;
    ticks(2);
    check_reset_outputs("rst_hold");
    rst = 1'b0;

    // Column sequence over two full scan periods
    for (int k = 0; k < 66; k++) begin
      if (k % 33 < 16) begin
        exp_col = 4'b0001 << ((k % 33) / 4);
        exp_col = ~exp_col;
      end else begin
        exp_col = 4'hF;
      end
      check($sformatf("col_k%0d", k), 32'(column_pins), 32'(exp_col));
      if (k == 0) check_reset_outputs("rst_after");
      tick();
    end
    check("scan_no_valid", 32'(valid_cnt), 32'd0);
    $display("reset/column sequence done: %0d checks", n_checks);

    // Clean press of key 6 (row 1, column 2)
    goto_phase(0);
    key_ready = 1'b1;
    pressed = 16'h0040;
    base_v = valid_cnt;
    base_p = pop_n;
    ticks(66);
    goto_phase(16);
    check("press_pre_update", 32'(keys_stable), 32'h0);
    tick();
    check("press_stable", 32'(keys_stable), 32'h0040);
    goto_phase(24);
    check("press_valid", 32'(key_valid), 32'h1);
    check("press_code", 32'(key_code), 32'h6);
    tick();
    check("press_popped", 32'(key_valid), 32'h0);
    goto_phase(0);
    check("press_valid_cycles", 32'(valid_cnt - base_v), 32'd1);
    check("press_pop_count", 32'(pop_n - base_p), 32'd1);
    check("press_pop_code", 32'(pop_log[base_p]), 32'd6);
    pressed = 16'h0;
    ticks(132);
    check("release_stable", 32'(keys_stable), 32'h0);
    check("release_no_event", 32'(pop_n - base_p), 32'd1);
    $display("clean press: code %0d popped, release silent", pop_log[base_p]);

    // Bounce: 2 scans on, 1 off, 2 on
    goto_phase(0);
    base_v = valid_cnt;
    base_p = pop_n;
    pressed = 16'h0040; ticks(66);
    pressed = 16'h0;    ticks(33);
    pressed = 16'h0040; ticks(66);
    check("bounce_stable", 32'(keys_stable), 32'h0);
    pressed = 16'h0;
    ticks(66);
    check("bounce_stable_end", 32'(keys_stable), 32'h0);
    check("bounce_no_valid", 32'(valid_cnt - base_v), 32'd0);
    check("bounce_no_pop", 32'(pop_n - base_p), 32'd0);
    $display("bounce: stable=%0h", keys_stable);

    // Simultaneous presses of keys 1 and 12, consumer stalled
    goto_phase(0);
    key_ready = 1'b0;
    base_p = pop_n;
    pressed = 16'h1002;
    ticks(99);
    check("simul_stable", 32'(keys_stable), 32'h1002);
    check("simul_valid", 32'(key_valid), 32'h1);
    check("simul_head", 32'(key_code), 32'h1);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    check("simul_second_valid", 32'(key_valid), 32'h1);
    check("simul_second", 32'(key_code), 32'hC);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    check("simul_empty", 32'(key_valid), 32'h0);
    check("simul_pops", 32'(pop_n - base_p), 32'd2);
    check("simul_pop0", 32'(pop_log[base_p]), 32'd1);
    check("simul_pop1", 32'(pop_log[base_p + 1]), 32'd12);
    pressed = 16'h0;
    goto_phase(0);
    ticks(132);
    check("simul_rel_stable", 32'(keys_stable), 32'h0);
    check("simul_rel_valid", 32'(key_valid), 32'h0);
    check("simul_rel_pops", 32'(pop_n - base_p), 32'd2);
    $display("simultaneous: popped %0d then %0d", pop_log[base_p], pop_log[base_p + 1]);

    // Overflow: five keys accepted into a 4-deep FIFO
    goto_phase(0);
    key_ready = 1'b0;
    pressed = 16'h8229;
    ticks(66);
    goto_phase(17);
    check("ovf_before", 32'(overflow), 32'h0);
    goto_phase(0);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_stable", 32'(keys_stable), 32'h8229);
    check("ovf_valid", 32'(key_valid), 32'h1);
    check("ovf_head", 32'(key_code), 32'h0);
    base_p = pop_n;
    key_ready = 1'b1;
    ticks(6);
    check("ovf_pops", 32'(pop_n - base_p), 32'd4);
    check("ovf_pop0", 32'(pop_log[base_p]), 32'd0);
    check("ovf_pop1", 32'(pop_log[base_p + 1]), 32'd3);
    check("ovf_pop2", 32'(pop_log[base_p + 2]), 32'd5);
    check("ovf_pop3", 32'(pop_log[base_p + 3]), 32'd9);
    check("ovf_drained", 32'(key_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    pressed = 16'h0;
    ticks(132);
    check("ovf_rel_stable", 32'(keys_stable), 32'h0);
    check("ovf_rel_sticky", 32'(overflow), 32'h1);
    check("ovf_rel_pops", 32'(pop_n - base_p), 32'd4);
    $display("overflow: 4 codes popped, overflow=%0b", overflow);

    // Reset in EMIT cycle 2 with keys 4 and 7 pending
    goto_phase(0);
    key_ready = 1'b1;
    pressed = 16'h0090;
    ticks(66);
    goto_phase(19);
    rst = 1'b1;
    pressed = 16'h0;
    base_v = valid_cnt;
    base_p = pop_n;
    tick();
    check_reset_outputs("midrst_hold");
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst_after");
    ticks(99);
    check("midrst_no_valid", 32'(valid_cnt - base_v), 32'd0);
    check("midrst_no_pop", 32'(pop_n - base_p), 32'd0);
    check("midrst_stable", 32'(keys_stable), 32'h0);
    check("midrst_ovf", 32'(overflow), 32'h0);
    $display("reset mid-EMIT: valid cycles after reset %0d", valid_cnt - base_v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
